obi_data_mem_responder: RTL and testbench
=========================================

Name: obi_data_mem_responder

Overview:
- Memory-side responder for the RI5CY core's data memory interface (req/gnt/rvalid protocol), i.e. the slave end of data_req_o/data_gnt_i/data_rvalid_i.
- Holds a word-addressed RAM with byte-enable writes, a programmable grant wait and a fixed response latency.
- Replaces hand-tied data_gnt_i/data_rvalid_i in the core testbench so loads and stores complete with real data.
- Includes a backdoor write port for preloading memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- MEM_DEPTH, 1024, number of 32-bit words (power of two, >=2).
- GNT_WAIT, 0, cycles req must be held high before gnt is given (0..15).
- RESP_LAT, 1, cycles from grant edge to rvalid (1..8).
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned for out-of-range reads.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- data_req_i  in  1  request from core; core holds addr/we/be/wdata stable until gnt.
- data_gnt_o  out  1  request accepted this cycle.
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_we_i  in  1  1 = store, 0 = load.
- data_be_i  in  4  byte lane enables, bit n = bits [8n+7:8n].
- data_wdata_i  in  32  store data.
- data_rvalid_o  out  1  response valid, one cycle per granted request.
- data_rdata_o  out  32  load data; 0 for stores.
- data_err_o  out  1  qualifies rvalid: address out of range.
- bd_we_i  in  1  backdoor word write.
- bd_addr_i  in  32  backdoor word index (not a byte address).
- bd_wdata_i  in  32  backdoor data.

Behaviour:
- Reset:
  - rst_i high at a rising edge clears: wait counter, response pipeline, data_rvalid_o, data_rdata_o, data_err_o.
  - data_gnt_o is 0 while rst_i is high.
  - RAM contents are retained.
  - Responses in flight are discarded; no rvalid for them after reset.
- Range check:
  - in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*MEM_DEPTH).
  - idx = (addr - BASE_ADDR) >> 2, truncated to log2(MEM_DEPTH) bits.
- Grant:
  - wait_cnt is a 4-bit counter.
  - data_gnt_o = data_req_i && (wait_cnt == GNT_WAIT) && !rst_i. This is combinational; with GNT_WAIT = 0 the grant is in the same cycle as req.
  - Each edge with req high and no gnt: wait_cnt increments.
  - Edge with gnt: wait_cnt returns to 0.
  - Edge with req low: wait_cnt returns to 0 (req withdrawn before grant is a core violation; no effect on memory).
- Back-to-back: with GNT_WAIT = 0, a new request is granted every cycle; throughput is 1 per cycle.
- Store, on the grant edge, if in_range:
  - RAM[idx] byte n <= wdata byte n for each be[n] = 1. be = 0 is a legal no-op.
  - Out-of-range store: write dropped.
- Load, on the grant edge:
  - Captures RAM[idx] (full word, be ignored), or ERR_RDATA if out of range.
  - The value is the RAM content before any write committed on the same edge.
- Response pipeline:
  - Shift register of depth RESP_LAT carrying {valid, err, rdata}.
  - Grant at edge k gives data_rvalid_o = 1 in the cycle after edge k+RESP_LAT-1; with RESP_LAT = 1, rvalid is high the cycle right after gnt.
  - Responses are in grant order, one rvalid cycle each.
  - The core has no ready, so responses are never stalled.
- Outputs when data_rvalid_o = 0: data_rdata_o and data_err_o are 0.
- Stores respond with rdata = 0; err = 1 if out of range.
- Backdoor:
  - bd_we_i writes RAM[bd_addr_i] on the edge; out-of-range index is ignored.
  - Same edge and same word as a granted core store: core store wins on its enabled bytes, backdoor on the others.
  - Same edge as a granted load of that word: load returns the old value.
- Reset asserted in the same cycle as gnt would be: gnt is forced 0, so no write and no response.

Test Plan:
- Reset, then GNT_WAIT=0, RESP_LAT=1: store 0x1122_3344 to 0x10 with be=4'hF, then load 0x10 -> gnt same cycle as req; load rvalid one cycle after its gnt with rdata = 0x1122_3344, err = 0.
- Byte enables: preload word 4 = 0xAAAA_AAAA via backdoor; store 0x5566_7788 to 0x10 with be=4'b0101; load 0x10 -> rdata = 0xAA66_AA88.
- GNT_WAIT=3, RESP_LAT=2: req held -> gnt on the 4th req cycle; rvalid 2 cycles after the gnt edge.
- Back-to-back: 8 consecutive loads of 0x0..0x1C with req held continuously -> 8 gnts in 8 cycles; 8 consecutive rvalids with rdata in address order.
- Out of range: load 0x4000 (MEM_DEPTH=1024) -> rdata = 0xDEAD_BEEF, err = 1. Store to it -> RAM unchanged, response err = 1, rdata = 0.
- Reset mid-flight, RESP_LAT=4: grant a load, assert rst_i 2 cycles later -> no rvalid ever for that load; RAM still holds its preloaded data after reset.

Source files
------------

// File: rtl/obi_data_mem_responder.sv
// rtl/obi_data_mem_responder.sv - data-side req/gnt/rvalid memory responder
// Word RAM with byte-enable stores, programmable grant wait and fixed response latency.
module obi_data_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_DEPTH = 1024,
  parameter int          GNT_WAIT  = 0,
  parameter int          RESP_LAT  = 1,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        bd_we_i,
  input  logic [31:0] bd_addr_i,
  input  logic [31:0] bd_wdata_i
);

  localparam int          AW       = $clog2(MEM_DEPTH);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEM_DEPTH);

  logic [31:0]         mem [MEM_DEPTH];
  logic [3:0]          wait_cnt;
  logic [31:0]         offset;
  logic [AW-1:0]       idx;
  logic [AW-1:0]       bd_idx;
  logic                in_range;
  logic                bd_ok;
  logic [31:0]         rd_word;
  logic [RESP_LAT-1:0] pipe_valid;
  logic [RESP_LAT-1:0] pipe_err;
  logic [31:0]         pipe_data [RESP_LAT];
  logic                unused_offset_bits;

  assign offset             = data_addr_i - BASE_ADDR;
  assign idx                = offset[AW+1:2];
  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};
  assign in_range           = ({1'b0, data_addr_i} >= {1'b0, BASE_ADDR}) &&
                              ({1'b0, data_addr_i} < END_ADDR);
  assign bd_ok              = bd_we_i && (bd_addr_i < 32'(MEM_DEPTH));
  assign bd_idx             = bd_addr_i[AW-1:0];
  assign rd_word            = mem[idx];

  assign data_gnt_o = data_req_i && (wait_cnt == 4'(GNT_WAIT)) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= 4'd0;
    end else if (!data_req_i || data_gnt_o) begin
      wait_cnt <= 4'd0;
    end else begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Core store is written after the backdoor so it wins on its enabled bytes.
  always_ff @(posedge clk_i) begin
    if (bd_ok) begin
      mem[bd_idx] <= bd_wdata_i;
    end
    if (data_gnt_o && data_we_i && in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (data_be_i[n]) begin
          mem[idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < RESP_LAT; i++) begin
        pipe_data[i] <= 32'd0;
      end
    end else begin
      for (int i = RESP_LAT - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
      pipe_valid[0] <= data_gnt_o;
      pipe_err[0]   <= data_gnt_o && !in_range;
      pipe_data[0]  <= (data_gnt_o && !data_we_i) ? (in_range ? rd_word : ERR_RDATA) : 32'd0;
    end
  end

  assign data_rvalid_o = pipe_valid[RESP_LAT-1];
  assign data_err_o    = pipe_err[RESP_LAT-1];
  assign data_rdata_o  = pipe_data[RESP_LAT-1];

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// tb/tb_obi_data_mem_responder.sv - directed bench for obi_data_mem_responder
// Three instances cover (wait 0, lat 1), (wait 3, lat 2) and (wait 0, lat 4).
module tb_obi_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, bd_addr, bd_wdata;
  logic        we, bd_we;
  logic [3:0]  be;
  logic        req_a, req_b, req_c;
  logic        gnt_a, gnt_b, gnt_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        err_a, err_b, err_c;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  obi_data_mem_responder #(.GNT_WAIT(0), .RESP_LAT(1)) u_a (
    .clk_i(clk), .rst_i(rst), .data_req_i(req_a), .data_gnt_o(gnt_a),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid_a), .data_rdata_o(rdata_a), .data_err_o(err_a),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata));

  obi_data_mem_responder #(.GNT_WAIT(3), .RESP_LAT(2)) u_b (
    .clk_i(clk), .rst_i(rst), .data_req_i(req_b), .data_gnt_o(gnt_b),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid_b), .data_rdata_o(rdata_b), .data_err_o(err_b),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata));

  obi_data_mem_responder #(.GNT_WAIT(0), .RESP_LAT(4)) u_c (
    .clk_i(clk), .rst_i(rst), .data_req_i(req_c), .data_gnt_o(gnt_c),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid_c), .data_rdata_o(rdata_c), .data_err_o(err_c),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    tick();
    bd_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    addr = 32'h0; wdata = 32'h0; we = 1'b0; be = 4'h0;
    bd_we = 1'b0; bd_addr = 32'h0; bd_wdata = 32'h0;
    tick(); tick();

    // Reset state; gnt suppressed while reset is high
    req_a = 1'b1; #1;
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_rvalid", 32'(rvalid_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    req_a = 1'b0; rst = 1'b0;
    tick();

    // Full-word store then load
    addr = 32'h10; we = 1'b1; be = 4'hF; wdata = 32'h1122_3344; req_a = 1'b1; #1;
    chk("st_gnt_same_cycle", 32'(gnt_a), 32'd1);
    tick();
    we = 1'b0; #1;
    chk("ld_gnt", 32'(gnt_a), 32'd1);
    chk("st_rvalid", 32'(rvalid_a), 32'd1);
    chk("st_rdata_zero", rdata_a, 32'd0);
    chk("st_err", 32'(err_a), 32'd0);
    tick();
    req_a = 1'b0;
    chk("ld_rvalid", 32'(rvalid_a), 32'd1);
    chk("ld_rdata", rdata_a, 32'h1122_3344);
    chk("ld_err", 32'(err_a), 32'd0);
    tick();
    chk("idle_rvalid", 32'(rvalid_a), 32'd0);
    chk("idle_rdata", rdata_a, 32'd0);

    // Byte enables
    bd_write(32'd4, 32'hAAAA_AAAA);
    addr = 32'h10; we = 1'b1; be = 4'b0101; wdata = 32'h5566_7788; req_a = 1'b1;
    tick();
    we = 1'b0;
    tick();
    req_a = 1'b0;
    chk("be_merge", rdata_a, 32'hAA66_AA88);

    // Backdoor and core store to the same word on the same edge
    bd_we = 1'b1; bd_addr = 32'd5; bd_wdata = 32'hFFFF_FFFF;
    addr = 32'h14; we = 1'b1; be = 4'b0011; wdata = 32'h1234_5678; req_a = 1'b1;
    tick();
    bd_wdata = 32'h0000_0000; we = 1'b0;
    tick();
    bd_we = 1'b0;
    chk("bd_core_collide", rdata_a, 32'hFFFF_5678);
    tick();
    req_a = 1'b0;
    chk("bd_after_load", rdata_a, 32'h0000_0000);
    tick();

    // Grant wait 3, latency 2
    addr = 32'h10; we = 1'b0; be = 4'hF; req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wait_gnt_%0d", i), 32'(gnt_b), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    req_b = 1'b0;
    chk("lat2_not_yet", 32'(rvalid_b), 32'd0);
    tick();
    chk("lat2_rvalid", 32'(rvalid_b), 32'd1);
    chk("lat2_rdata", rdata_b, 32'hAAAA_AAAA);
    tick();

    // Back-to-back loads of eight words
    for (int i = 0; i < 8; i++) bd_write(32'(i), 32'h1000_0000 + 32'(i));
    we = 1'b0; be = 4'hF; req_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr = 32'(4 * i); #1;
      chk($sformatf("b2b_gnt_%0d", i), 32'(gnt_a), 32'd1);
      if (i > 0) begin
        chk($sformatf("b2b_rvalid_%0d", i - 1), 32'(rvalid_a), 32'd1);
        chk($sformatf("b2b_rdata_%0d", i - 1), rdata_a, 32'h1000_0000 + 32'(i - 1));
      end
      tick();
    end
    req_a = 1'b0;
    chk("b2b_rvalid_7", 32'(rvalid_a), 32'd1);
    chk("b2b_rdata_7", rdata_a, 32'h1000_0007);
    tick();
    chk("b2b_end", 32'(rvalid_a), 32'd0);

    // Out of range load and store
    addr = 32'h4000; we = 1'b0; req_a = 1'b1; #1;
    chk("oor_gnt", 32'(gnt_a), 32'd1);
    tick();
    we = 1'b1; wdata = 32'h1234_5678; be = 4'hF;
    chk("oor_ld_rdata", rdata_a, 32'hDEAD_BEEF);
    chk("oor_ld_err", 32'(err_a), 32'd1);
    tick();
    req_a = 1'b0; we = 1'b0;
    chk("oor_st_rvalid", 32'(rvalid_a), 32'd1);
    chk("oor_st_rdata", rdata_a, 32'd0);
    chk("oor_st_err", 32'(err_a), 32'd1);
    addr = 32'h0; req_a = 1'b1;
    tick();
    req_a = 1'b0;
    chk("oor_word0_kept", rdata_a, 32'h1000_0000);
    chk("inrange_err", 32'(err_a), 32'd0);
    tick();

    // Reset while a latency-4 load is in flight
    bd_write(32'd2, 32'hCAFE_F00D);
    addr = 32'h8; we = 1'b0; req_c = 1'b1; #1;
    chk("c_gnt", 32'(gnt_c), 32'd1);
    tick();
    req_c = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("flush_rvalid_%0d", i), 32'(rvalid_c), 32'd0);
      tick();
    end
    req_c = 1'b1;
    tick();
    req_c = 1'b0;
    tick(); tick();
    chk("c_lat_not_yet", 32'(rvalid_c), 32'd0);
    tick();
    chk("c_rvalid", 32'(rvalid_c), 32'd1);
    chk("c_ram_kept", rdata_c, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
